street_scroll_scheduler: RTL and testbench

STREET_SCROLL_SCHEDULER -- requirements
Module: street_scroll_scheduler

---
 rtl/background_pkg.sv | 37 +++
 rtl/bg_lfsr.sv | 27 ++
 rtl/street_scroll_scheduler.sv | 131 +++++++++++++
 tb/tb_street_scroll_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/background_pkg.sv
// rtl/background_pkg.sv - shared screen geometry, tile tables and scheduler types
package background_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 11;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREET = 2'd1,
      ST_GROUND = 2'd2
   } state_e;

   // Start X of each ground tile; tiles beyond the table reuse it cyclically.
   localparam int GROUND_X_TABLE_N = 8;
   localparam coord_t GROUND_X_INIT [GROUND_X_TABLE_N] = '{
      11'd80, 11'd240, 11'd400, 11'd560, 11'd160, 11'd320, 11'd480, 11'd0
   };

   // True when moving down by step carries the tile past the bottom edge.
   function automatic logic wraps(input coord_t y, input logic [3:0] step);
      return (y + coord_t'(step)) >= coord_t'(SCREEN_H);
   endfunction

   // Scroll down by step and re-enter at the top without leaving a gap.
   function automatic coord_t wrap_add(input coord_t y, input logic [3:0] step);
      coord_t sum;
      sum = y + coord_t'(step);
      if (wraps(y, step)) begin
         return sum - coord_t'(SCREEN_H);
      end
      return sum;
   endfunction

endpackage

// File: rtl/bg_lfsr.sv
// rtl/bg_lfsr.sv - free-running 16-bit Fibonacci LFSR for random ground X
module bg_lfsr (
   input  logic       clk,
   input  logic       resetN,
   output logic [8:0] lfsr_low
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Shift left, feedback from taps 16,14,13,11.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Advances every cycle; nonzero seed keeps it out of the lock-up state.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_low = lfsr_q[8:0];

endmodule

// File: rtl/street_scroll_scheduler.sv
// rtl/street_scroll_scheduler.sv - per-frame scroll of street and ground tiles (option: RANDOM_GROUND_EN)
module street_scroll_scheduler
   import background_pkg::*;
#(
   parameter int NUM_STREET = 10,
   parameter int NUM_GROUND = 4,
   parameter int TILE_PITCH = 48
) (
   input  logic                                clk,
   input  logic                                resetN,
   input  logic                                startOfFrame,
   input  logic                                enable,
   input  logic [3:0]                          speed,
   output logic [NUM_STREET-1:0][COORD_W-1:0]  streetTileY,
   output logic [NUM_GROUND-1:0][COORD_W-1:0]  groundTileX,
   output logic [NUM_GROUND-1:0][COORD_W-1:0]  groundTileY,
   output logic                                busy,
   output logic                                frameDone
);

   localparam int IDX_MAX = (NUM_STREET > NUM_GROUND) ? NUM_STREET : NUM_GROUND;
   localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

   state_e                              state_q, state_d;
   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic [3:0]                          speed_q, speed_d;
   logic                                done_q, done_d;
   logic [NUM_STREET-1:0][COORD_W-1:0]  street_y_q, street_y_d;
   logic [NUM_GROUND-1:0][COORD_W-1:0]  ground_x_q, ground_x_d;
   logic [NUM_GROUND-1:0][COORD_W-1:0]  ground_y_q, ground_y_d;

`ifdef RANDOM_GROUND_EN
   logic [8:0] lfsr_low;

   bg_lfsr u_lfsr (
      .clk      (clk),
      .resetN   (resetN),
      .lfsr_low (lfsr_low)
   );
`endif

   // Pass sequencer: one street tile per cycle, then one ground tile per cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      speed_d    = speed_q;
      done_d     = 1'b0;
      street_y_d = street_y_q;
      ground_x_d = ground_x_q;
      ground_y_d = ground_y_q;
      case (state_q)
         ST_IDLE: begin
            if (startOfFrame && enable) begin
               state_d = ST_STREET;
               idx_d   = '0;
               speed_d = speed;
            end
         end
         ST_STREET: begin
            for (int i = 0; i < NUM_STREET; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  street_y_d[i] = wrap_add(street_y_q[i], speed_q);
               end
            end
            if (idx_q == IDX_W'(NUM_STREET - 1)) begin
               state_d = ST_GROUND;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_GROUND: begin
            for (int i = 0; i < NUM_GROUND; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  ground_y_d[i] = wrap_add(ground_y_q[i], speed_q);
                  if (wraps(ground_y_q[i], speed_q)) begin
`ifdef RANDOM_GROUND_EN
                     ground_x_d[i] = {2'b0, lfsr_low};
`else
                     ground_x_d[i] = GROUND_X_INIT[i % GROUND_X_TABLE_N];
`endif
                  end
               end
            end
            if (idx_q == IDX_W'(NUM_GROUND - 1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and tile registers; reset restores the initial tile layout.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         speed_q <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NUM_STREET; i++) begin
            street_y_q[i] <= coord_t'(i * TILE_PITCH);
         end
         for (int i = 0; i < NUM_GROUND; i++) begin
            ground_y_q[i] <= coord_t'(i * (SCREEN_H / NUM_GROUND));
            ground_x_q[i] <= GROUND_X_INIT[i % GROUND_X_TABLE_N];
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         speed_q    <= speed_d;
         done_q     <= done_d;
         street_y_q <= street_y_d;
         ground_x_q <= ground_x_d;
         ground_y_q <= ground_y_d;
      end
   end

   assign streetTileY = street_y_q;
   assign groundTileX = ground_x_q;
   assign groundTileY = ground_y_q;
   assign busy        = (state_q != ST_IDLE);
   assign frameDone   = done_q;

endmodule

// File: tb/tb_street_scroll_scheduler.sv
// tb/tb_street_scroll_scheduler.sv - self-checking bench for street_scroll_scheduler
module tb_street_scroll_scheduler;

   localparam int NS = 10;
   localparam int NG = 4;
   localparam int H  = 480;

   logic                    clk;
   logic                    resetN;
   logic                    startOfFrame;
   logic                    enable;
   logic [3:0]              speed;
   logic [NS-1:0][10:0]     streetTileY;
   logic [NG-1:0][10:0]     groundTileX;
   logic [NG-1:0][10:0]     groundTileY;
   logic                    busy;
   logic                    frameDone;

   street_scroll_scheduler #(.NUM_STREET(NS), .NUM_GROUND(NG), .TILE_PITCH(48)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (enable),
      .speed        (speed),
      .streetTileY  (streetTileY),
      .groundTileX  (groundTileX),
      .groundTileY  (groundTileY),
      .busy         (busy),
      .frameDone    (frameDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NS-1:0][10:0] st;
      logic [NG-1:0][10:0] gy;
      logic [NG-1:0][10:0] gx;
   } snap_t;

   typedef struct {
      logic [3:0] spd;
      int         s9;
      int         g3;
   } vec_t;

   snap_t               sb[$];
   logic [NS-1:0][10:0] m_st;
   logic [NG-1:0][10:0] m_gy;
   logic [NG-1:0][10:0] m_gx;
   int                  gx_init [NG] = '{80, 240, 400, 560};
   int                  errors = 0;
   int                  checks = 0;
   vec_t                vecs [12];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_st[i] = 11'(i * 48);
      for (int i = 0; i < NG; i++) begin
         m_gy[i] = 11'(i * (H / NG));
         m_gx[i] = 11'(gx_init[i]);
      end
   endtask

   task automatic model_push(input logic [3:0] s);
      snap_t e;
      for (int i = 0; i < NS; i++) m_st[i] = 11'((int'(m_st[i]) + int'(s)) % H);
      for (int i = 0; i < NG; i++) begin
         if (int'(m_gy[i]) + int'(s) >= H) m_gx[i] = 11'(gx_init[i]);
         m_gy[i] = 11'((int'(m_gy[i]) + int'(s)) % H);
      end
      e.st = m_st;
      e.gy = m_gy;
      e.gx = m_gx;
      sb.push_back(e);
   endtask

   task automatic check_coords(input string tag, input snap_t e);
      check({tag, "_streetY"}, streetTileY, e.st);
      check({tag, "_groundY"}, groundTileY, e.gy);
      check({tag, "_groundX"}, groundTileX, e.gx);
   endtask

   // Runs one pass; disturb re-pulses startOfFrame, drops enable and changes speed mid-pass.
   task automatic run_pass(input logic [3:0] s, input bit disturb);
      int    busy_n;
      int    done_n;
      bit    seen;
      snap_t e;
      busy_n = 0;
      done_n = 0;
      seen   = 1'b0;
      @(negedge clk);
      startOfFrame = 1'b1;
      enable       = 1'b1;
      speed        = s;
      model_push(s);
      @(negedge clk);
      startOfFrame = 1'b0;
      check("busy_after_accept", busy, 1);
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (busy) busy_n++;
         if (frameDone) begin
            done_n++;
            if (!seen) begin
               seen = 1'b1;
               check("done_cycle", c, 15);
               check("busy_at_done", busy, 0);
               if (sb.size() == 0) begin
                  check("scoreboard_nonempty", 0, 1);
               end else begin
                  e = sb.pop_front();
                  check_coords("pass", e);
               end
            end
         end
         if (disturb) begin
            if (c == 2) speed = 4'd9;
            startOfFrame = (c == 3);
            enable       = (c != 5);
         end
      end
      startOfFrame = 1'b0;
      enable       = 1'b1;
      check("busy_cycles", busy_n, 14);
      check("done_count", done_n, 1);
   endtask

   initial begin
      int busy_seen;
      int done_seen;
      snap_t r;

      vecs[0]  = '{4'd5,  437, 365};
      vecs[1]  = '{4'd15, 452, 380};
      vecs[2]  = '{4'd15, 467, 395};
      vecs[3]  = '{4'd10, 477, 405};
      vecs[4]  = '{4'd7,  4,   412};
      vecs[5]  = '{4'd15, 19,  427};
      vecs[6]  = '{4'd15, 34,  442};
      vecs[7]  = '{4'd15, 49,  457};
      vecs[8]  = '{4'd15, 64,  472};
      vecs[9]  = '{4'd3,  67,  475};
      vecs[10] = '{4'd8,  75,  3};
      vecs[11] = '{4'd0,  75,  3};

      resetN       = 1'b0;
      startOfFrame = 1'b0;
      enable       = 1'b1;
      speed        = 4'd0;
      model_reset();
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      r.st = m_st;
      r.gy = m_gy;
      r.gx = m_gx;
      check_coords("reset", r);
      check("reset_busy", busy, 0);
      check("reset_done", frameDone, 0);

      for (int v = 0; v < 12; v++) begin
         run_pass(vecs[v].spd, 1'b0);
         check("tbl_streetY9", streetTileY[9], 128'(vecs[v].s9));
         check("tbl_groundY3", groundTileY[3], 128'(vecs[v].g3));
         if (v == 0) check("tbl_streetY0", streetTileY[0], 5);
         if (v == 10) check("tbl_groundX3", groundTileX[3], 560);
      end

      run_pass(4'd2, 1'b1);

      // startOfFrame with enable low while idle must not start a pass.
      @(negedge clk);
      enable       = 1'b0;
      startOfFrame = 1'b1;
      speed        = 4'd6;
      @(negedge clk);
      startOfFrame = 1'b0;
      enable       = 1'b1;
      busy_seen = 0;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (busy) busy_seen++;
         if (frameDone) done_seen++;
         @(negedge clk);
      end
      check("disabled_busy", busy_seen, 0);
      check("disabled_done", done_seen, 0);
      r.st = m_st;
      r.gy = m_gy;
      r.gx = m_gx;
      check_coords("disabled_hold", r);

      // Reset asserted at pass cycle 6 discards the pass.
      startOfFrame = 1'b1;
      speed        = 4'd4;
      @(negedge clk);
      startOfFrame = 1'b0;
      repeat (5) @(negedge clk);
      check("midpass_busy_before", busy, 1);
      resetN = 1'b0;
      #1;
      sb.delete();
      model_reset();
      r.st = m_st;
      r.gy = m_gy;
      r.gx = m_gx;
      check("midreset_busy", busy, 0);
      check("midreset_done", frameDone, 0);
      check_coords("midreset", r);
      @(negedge clk);
      resetN = 1'b1;
      busy_seen = 0;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (frameDone) done_seen++;
      end
      check("postreset_busy", busy_seen, 0);
      check("postreset_done", done_seen, 0);
      check_coords("postreset", r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
